// File: rtl/ingress_rdreq_sched_if.sv
// rtl/ingress_rdreq_sched_if.sv - parser, register bank and completion signals of the read scheduler
interface ingress_rdreq_sched_if;
  logic        rd_req;
  logic [9:0]  rd_tdest;
  logic        reg_rd_en;
  logic [1:0]  reg_rd_action;
  logic [3:0]  reg_rd_chnl;
  logic [2:0]  reg_rd_addr;
  logic        reg_rd_vld;
  logic [31:0] reg_rd_data;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [31:0] cpl_data;
  logic        cpl_err;
  logic        ovf_err;
  logic        busy;

  modport slave (
    input  rd_req, rd_tdest, reg_rd_vld, reg_rd_data, cpl_ready,
    output reg_rd_en, reg_rd_action, reg_rd_chnl, reg_rd_addr,
    output cpl_valid, cpl_data, cpl_err, ovf_err, busy
  );

  modport master (
    output rd_req, rd_tdest, reg_rd_vld, reg_rd_data, cpl_ready,
    input  reg_rd_en, reg_rd_action, reg_rd_chnl, reg_rd_addr,
    input  cpl_valid, cpl_data, cpl_err, ovf_err, busy
  );
endinterface

// File: rtl/ingress_rdreq_sched.sv
// rtl/ingress_rdreq_sched.sv - PIO register read sequencer
// Queues parsed read destinations and services them one at a time, in order.
module ingress_rdreq_sched #(
  parameter int CHANNEL_NUM = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  ingress_rdreq_sched_if.slave        bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [4:0]       CH_LIM   = 5'(CHANNEL_NUM);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;

  state_t            state_q, state_d;
  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [8:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        action_q, action_d;
  logic [3:0]        chnl_q, chnl_d;
  logic [2:0]        addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       cpl_data_q, cpl_data_d;
  logic              cpl_err_q, cpl_err_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic              pop;
  logic              full;
  logic [8:0]        head;
  logic              unused_tdest;

  // Bit 9 of the destination is reserved and never stored.
  assign unused_tdest = bus.rd_tdest[9];

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    action_d   = action_q;
    chnl_d     = chnl_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    cpl_data_d = cpl_data_q;
    cpl_err_d  = cpl_err_q;
    ovf_d      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];
    full       = (count_q == FULL_CNT);

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          action_d = head[5:4];
          chnl_d   = head[3:0];
          addr_d   = head[8:6];
          if ((head[5:4] != 2'b11) && ({1'b0, head[3:0]} < CH_LIM)) begin
            state_d = S_ISSUE;
          end else begin
            state_d    = S_CPL;
            cpl_data_d = '0;
            cpl_err_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving on the last permitted cycle still beats the timeout.
        if (bus.reg_rd_vld) begin
          cpl_data_d = bus.reg_rd_data;
          cpl_err_d  = 1'b0;
          state_d    = S_CPL;
        end else if (tmo_q == TMO_LAST) begin
          cpl_data_d = '0;
          cpl_err_d  = 1'b1;
          state_d    = S_CPL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CPL: begin
        if (bus.cpl_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.rd_req) begin
      if (!full || pop) begin
        push = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = bus.rd_tdest[8:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      action_q   <= '0;
      chnl_q     <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      cpl_data_q <= '0;
      cpl_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      action_q   <= action_d;
      chnl_q     <= chnl_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      cpl_data_q <= cpl_data_d;
      cpl_err_q  <= cpl_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.reg_rd_en     = (state_q == S_ISSUE);
  assign bus.reg_rd_action = action_q;
  assign bus.reg_rd_chnl   = chnl_q;
  assign bus.reg_rd_addr   = addr_q;
  assign bus.cpl_valid     = (state_q == S_CPL);
  assign bus.cpl_data      = cpl_data_q;
  assign bus.cpl_err       = cpl_err_q;
  assign bus.ovf_err       = ovf_q;
  assign bus.busy          = (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_ingress_rdreq_sched.sv
// tb/tb_ingress_rdreq_sched.sv - scoreboard bench for the PIO register read sequencer
module tb_ingress_rdreq_sched;
  localparam int TMO = 64;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   n_cpl;
  int   n_strobe;
  int   ovf_cnt;

  logic [32:0] exp_q[$];
  logic [8:0]  exp_rd_q[$];
  logic [31:0] bank_q[$];
  int          bank_delay;
  int          bank_cnt;
  logic [31:0] bank_cur;

  ingress_rdreq_sched_if bus();

  ingress_rdreq_sched #(
    .CHANNEL_NUM(12),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; expectations are queued at issue time.
  task automatic send(input logic [9:0] td, input bit strobe, input logic [31:0] bdata,
                      input bit cpl, input bit err, input logic [31:0] edata);
    bus.rd_req   = 1'b1;
    bus.rd_tdest = td;
    if (strobe) begin
      exp_rd_q.push_back({td[5:4], td[3:0], td[8:6]});
      bank_q.push_back(bdata);
    end
    if (cpl) exp_q.push_back({err, edata});
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic wait_strobe(output int c);
    int n = 0;
    while (!bus.reg_rd_en && n < 20) begin
      tick();
      n++;
    end
    chk("strobe_seen", bus.reg_rd_en, 1);
    c = cyc;
  endtask

  task automatic wait_cpl(output int c);
    int n = 0;
    while (!bus.cpl_valid && n < 200) begin
      tick();
      n++;
    end
    chk("cpl_seen", bus.cpl_valid, 1);
    c = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_busy", bus.busy, 0);
  endtask

  // Register bank model: answers each strobe after bank_delay cycles (0 = never).
  initial begin
    bus.reg_rd_vld  = 1'b0;
    bus.reg_rd_data = '0;
    bank_cnt        = 0;
    bank_cur        = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.reg_rd_vld = 1'b0;
      if (rst) begin
        bank_cnt = 0;
      end else begin
        if (bank_cnt != 0) begin
          bank_cnt--;
          if (bank_cnt == 0) begin
            bus.reg_rd_vld  = 1'b1;
            bus.reg_rd_data = bank_cur;
          end
        end
        if (bus.reg_rd_en) begin
          bank_cnt = bank_delay;
          bank_cur = (bank_q.size() != 0) ? bank_q.pop_front() : 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: compares strobes and completions against the queued expectations.
  initial begin
    logic [32:0] e;
    logic [8:0]  r;
    forever begin
      @(negedge clk);
      if (!rst && bus.ovf_err) ovf_cnt++;
      if (!rst && bus.reg_rd_en) begin
        n_strobe++;
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_strobe", {bus.reg_rd_action, bus.reg_rd_chnl, bus.reg_rd_addr}, 32'h1FF);
        end else begin
          r = exp_rd_q.pop_front();
          chk("strobe_dest", {bus.reg_rd_action, bus.reg_rd_chnl, bus.reg_rd_addr}, r);
        end
      end
      if (!rst && bus.cpl_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cpl", {bus.cpl_err, bus.cpl_data}, 33'h1_FFFF_FFFF);
        end else begin
          e = exp_q[0];
          chk("cpl_data", bus.cpl_data, e[31:0]);
          chk("cpl_err", bus.cpl_err, e[32]);
          if (bus.cpl_ready) begin
            void'(exp_q.pop_front());
            n_cpl++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, c, base;
    logic [31:0] held;
    cyc = 0; n_chk = 0; n_err = 0; n_cpl = 0; n_strobe = 0; ovf_cnt = 0;
    bank_delay    = 1;
    rst           = 1'b1;
    bus.rd_req    = 1'b0;
    bus.rd_tdest  = '0;
    bus.cpl_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rd_en", bus.reg_rd_en, 0);
    chk("rst_action", bus.reg_rd_action, 0);
    chk("rst_chnl", bus.reg_rd_chnl, 0);
    chk("rst_addr", bus.reg_rd_addr, 0);
    chk("rst_cpl_valid", bus.cpl_valid, 0);
    chk("rst_cpl_data", bus.cpl_data, 0);
    chk("rst_cpl_err", bus.cpl_err, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    // Single TX read, latency T+2 strobe and T+4 completion.
    t0 = cyc;
    send(10'b0_000_00_0011, 1, 32'h0000_1000, 1, 0, 32'h0000_1000);
    chk("t1_en_T1", bus.reg_rd_en, 0);
    tick();
    chk("t1_en_T2", bus.reg_rd_en, 1);
    chk("t1_action", bus.reg_rd_action, 2'b00);
    chk("t1_chnl", bus.reg_rd_chnl, 3);
    chk("t1_addr", bus.reg_rd_addr, 0);
    tick();
    chk("t1_valid_T3", bus.cpl_valid, 0);
    tick();
    chk("t1_valid_T4", bus.cpl_valid, 1);
    chk("t1_cycle", cyc - t0, 4);
    drain();

    // Back-pressure and ordering.
    bus.cpl_ready = 1'b0;
    send({1'b0, 3'd3, 2'b10, 4'd0}, 1, 32'hA000_0003, 1, 0, 32'hA000_0003);
    send({1'b0, 3'd2, 2'b01, 4'd1}, 1, 32'hB000_0012, 1, 0, 32'hB000_0012);
    send({1'b0, 3'd1, 2'b00, 4'd0}, 1, 32'hC000_0001, 1, 0, 32'hC000_0001);
    for (int k = 0; k < 3; k++) begin
      wait_cpl(c);
      held = bus.cpl_data;
      repeat (10) tick();
      chk("stall_stable", bus.cpl_data, held);
      bus.cpl_ready = 1'b1;
      tick();
      bus.cpl_ready = 1'b0;
    end
    bus.cpl_ready = 1'b1;
    drain();
    chk("order_no_ovf", ovf_cnt, 0);
    chk("order_cpl_count", n_cpl, 4);

    // Invalid destinations: action 11, then channel 13.
    base = n_strobe;
    send({1'b0, 3'd0, 2'b11, 4'd2}, 0, 0, 1, 1, 32'h0);
    send({1'b0, 3'd1, 2'b00, 4'd13}, 0, 0, 1, 1, 32'h0);
    drain();
    chk("inv_no_strobe", n_strobe - base, 0);
    chk("inv_cpl_count", n_cpl, 6);

    // Timeout with no data, then data on the final wait cycle.
    bank_delay = 0;
    send({1'b0, 3'd5, 2'b01, 4'd11}, 1, 32'h0, 1, 1, 32'h0);
    wait_strobe(s);
    wait_cpl(c);
    chk("tmo_latency", c - s, TMO + 1);
    drain();
    bank_delay = TMO;
    send({1'b0, 3'd6, 2'b10, 4'd2}, 1, 32'h7777_0001, 1, 0, 32'h7777_0001);
    wait_strobe(s);
    wait_cpl(c);
    chk("tmo_last_latency", c - s, TMO + 1);
    drain();

    // Overflow: stall in CPL, then five more requests.
    bank_delay    = 1;
    bus.cpl_ready = 1'b0;
    send({1'b0, 3'd0, 2'b00, 4'd4}, 1, 32'h0000_0011, 1, 0, 32'h0000_0011);
    wait_cpl(c);
    base = n_cpl;
    for (int k = 0; k < 4; k++) begin
      send({1'b0, 3'(k), 2'b01, 4'(k + 5)}, 1, 32'h0000_0020 + k, 1, 0, 32'h0000_0020 + k);
    end
    send({1'b0, 3'd7, 2'b00, 4'd9}, 0, 0, 0, 0, 0);
    chk("ovf_pulse", bus.ovf_err, 1);
    chk("ovf_busy", bus.busy, 1);
    tick();
    chk("ovf_pulse_end", bus.ovf_err, 0);
    chk("ovf_count", ovf_cnt, 1);
    bus.cpl_ready = 1'b1;
    drain();
    chk("ovf_cpl_total", n_cpl - base, 5);

    // Reset while waiting on the bank with two requests queued.
    bank_delay = 0;
    base = n_cpl;
    send({1'b0, 3'd1, 2'b10, 4'd0}, 1, 32'h0, 0, 0, 0);
    send({1'b0, 3'd2, 2'b10, 4'd0}, 0, 0, 0, 0, 0);
    send({1'b0, 3'd3, 2'b10, 4'd0}, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_wait_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_busy", bus.busy, 0);
    chk("rst_wait_valid", bus.cpl_valid, 0);
    chk("rst_wait_en", bus.reg_rd_en, 0);
    repeat (5) tick();
    chk("rst_wait_no_cpl", n_cpl - base, 0);
    bank_delay = 1;
    send({1'b0, 3'd4, 2'b00, 4'd2}, 1, 32'h5A5A_0042, 1, 0, 32'h5A5A_0042);
    drain();
    chk("rst_recover_cpl", n_cpl - base, 1);
    chk("end_strobes_pending", exp_rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ingress_rdreq_sched.md
Name: ingress_rdreq_sched

Overview:
- Sequences PIO register reads decoded by the ingress read-request parser.
- Queues each {register,action,channel} destination word and issues one register read strobe at a time to the TX, RX or global register bank.
- Waits for the bank's read data, then hands a completion request to the egress completion builder with a valid/ready handshake.
- Provides in-order, one-outstanding read servicing with overflow and timeout protection.

Parameters:
- CHANNEL_NUM, 12, number of implemented DMA channels; channel fields >= CHANNEL_NUM are invalid.
- FIFO_DEPTH, 4, request queue depth; must be a power of 2, >= 2.
- TIMEOUT, 64, cycles to wait for bank read data before completing with error.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- rd_req, in, 1, single-cycle read request pulse from the parser.
- rd_tdest, in, 10, [3:0] channel, [5:4] action (00 tx, 01 rx, 10 global, 11 invalid), [8:6] register, [9] reserved.
- reg_rd_en, out, 1, one-cycle read strobe to the register banks.
- reg_rd_action, out, 2, target bank select; held stable from strobe until data or timeout.
- reg_rd_chnl, out, 4, target channel; held stable the same way.
- reg_rd_addr, out, 3, register index within the bank; held stable the same way.
- reg_rd_vld, in, 1, bank read data valid; sampled only in WAIT.
- reg_rd_data, in, 32, bank read data.
- cpl_valid, out, 1, completion request valid.
- cpl_ready, in, 1, egress accepts completion.
- cpl_data, out, 32, completion payload.
- cpl_err, out, 1, completion carries error status (UR); payload is 0.
- ovf_err, out, 1, one-cycle pulse when rd_req is dropped because the queue is full.
- busy, out, 1, high when the queue is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; FSM in IDLE; timeout counter 0. Reset applied mid-transaction aborts it with no completion emitted; a held cpl_valid drops the next cycle.
- Queue:
  - rd_req pushes rd_tdest into the FIFO in the same cycle.
  - Push and pop in the same cycle are legal when not full.
  - When full, a push is allowed only if a pop occurs in the same cycle; otherwise the request is dropped and ovf_err=1 for 1 cycle.
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap naturally.
- FSM states: IDLE, ISSUE, WAIT, CPL.
- IDLE:
  - If the FIFO is non-empty, pop the head into the context registers (action/chnl/addr).
  - Valid context (action != 11 and chnl < CHANNEL_NUM) -> ISSUE.
  - Invalid context -> CPL with cpl_err=1, cpl_data=0.
- ISSUE:
  - reg_rd_en=1 for exactly this cycle; clear the timeout counter.
  - Next state is WAIT.
- WAIT:
  - reg_rd_vld=1 -> capture reg_rd_data into cpl_data, cpl_err=0, go to CPL.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no vld -> CPL with cpl_err=1, cpl_data=0.
  - If vld and timeout coincide, vld wins.
  - reg_rd_vld outside WAIT is ignored.
- CPL:
  - cpl_valid=1. cpl_data and cpl_err stay stable until cpl_ready.
  - On cpl_valid && cpl_ready -> IDLE, with cpl_valid=0 the next cycle.
  - cpl_ready without cpl_valid has no effect.
- Latency:
  - Empty queue, vld arriving the cycle after strobe: rd_req at cycle T -> reg_rd_en at T+2, cpl_valid at T+4.
  - Minimum spacing between consecutive reg_rd_en is 4 cycles.
- Ordering: completions leave in rd_req arrival order. Only one read is outstanding at a time.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Single TX read: rd_req with tdest=10'b0_000_00_0011, bank returns vld with 0x0000_1000 one cycle after strobe, cpl_ready=1 -> reg_rd_en at T+2 with action=00, chnl=3, addr=0; cpl_valid at T+4 with data 0x0000_1000, err=0.
- Back-pressure and ordering: 3 requests on consecutive cycles (global addr 3, RX ch1 addr 2, TX ch0 addr 1), cpl_ready low for 10 cycles per completion -> three completions in that order, cpl_data stable while stalled, ovf_err never asserted.
- Overflow: with FIFO_DEPTH=4, the FSM stalled in CPL and 5 requests pushed -> the 5th raises ovf_err for 1 cycle; the queue holds 4; exactly 5 completions in total (1 in flight + 4 queued).
- Invalid destination: action=11, then channel=13 with CHANNEL_NUM=12 -> no reg_rd_en; each yields cpl_err=1, cpl_data=0.
- Timeout: bank never asserts vld -> cpl_valid at strobe+TIMEOUT+1 with err=1. A second run with vld on the final cycle -> err=0 with the captured data.
- Reset mid-WAIT: rst asserted during WAIT with 2 queued requests -> next cycle busy=0, cpl_valid=0, no completion emitted; a new request afterwards is serviced normally.
